// File: rtl/synaptic_array_pkg.sv
// Shared constants and helpers for the N-way synaptic array.
// Used by synaptic_core, reduce_tree and synaptic_array_nway.
package synaptic_array_pkg;

  localparam int CORE_BUS_W = 32;

  function automatic int sum_w(input int mwid, input int n);
    return mwid + $clog2(n);
  endfunction

  // value is an owid-bit signed quantity carried in 32 bits; clamp it into the mwid-bit range
  function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] value,
                                                   input int mwid, input int owid);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    if (owid <= mwid) return value;
    hi = (32'sd1 <<< (mwid - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (mwid - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/synaptic_array_reduce_tree.sv
// Pipelined pair-add reduction of N channels x P lanes into one P-lane result.
// Define SYN_ARRAY_SAT_EN to clamp the output stage to the MWID range.
module reduce_tree
  import synaptic_array_pkg::*;
#(
  parameter int N    = 4,
  parameter int P    = 64,
  parameter int MWID = 12
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [N*P*MWID-1:0]            in_data_i,
  output logic [P*sum_w(MWID,N)-1:0]     out_data_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic                           busy_o
);

  localparam int LV   = $clog2(N);
  localparam int OWID = sum_w(MWID, N);

  logic              en;
  logic [LV-1:0]     stage_v;
  logic              out_valid_q;
  logic [P*OWID-1:0] out_q;
  logic [P*OWID-1:0] out_d;

  // one global advance: the whole pipe moves or freezes together
  assign en         = !out_valid_q || out_ready_i;
  assign in_ready_o = en;

  for (genvar s = 0; s < LV; s++) begin : g_st
    localparam int NN = N >> (s + 1);
    localparam int W  = MWID + s + 1;

    logic signed [W-2:0] opa    [NN][P];
    logic signed [W-2:0] opb    [NN][P];
    logic signed [W-1:0] node_q [NN][P];
    logic                v_in;
    logic                v_q;

    if (s == 0) begin : g_src
      always_comb begin
        v_in = in_valid_i;
        for (int n = 0; n < NN; n++) begin
          for (int k = 0; k < P; k++) begin
            opa[n][k] = in_data_i[((2*n)*P + k)*MWID +: MWID];
            opb[n][k] = in_data_i[((2*n+1)*P + k)*MWID +: MWID];
          end
        end
      end
    end else begin : g_src
      always_comb begin
        v_in = g_st[s-1].v_q;
        for (int n = 0; n < NN; n++) begin
          for (int k = 0; k < P; k++) begin
            opa[n][k] = g_st[s-1].node_q[2*n][k];
            opb[n][k] = g_st[s-1].node_q[2*n+1][k];
          end
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        v_q <= 1'b0;
      end else if (en) begin
        v_q <= v_in;
      end
    end

    always_ff @(posedge clk_i) begin
      if (en) begin
        for (int n = 0; n < NN; n++) begin
          for (int k = 0; k < P; k++) begin
            node_q[n][k] <= {opa[n][k][W-2], opa[n][k]} + {opb[n][k][W-2], opb[n][k]};
          end
        end
      end
    end

    assign stage_v[s] = v_q;
  end

  always_comb begin
    out_d = '0;
    for (int k = 0; k < P; k++) begin
`ifdef SYN_ARRAY_SAT_EN
      out_d[k*OWID +: OWID] = OWID'(sat_clamp(32'(g_st[LV-1].node_q[0][k]), MWID, OWID));
`else
      out_d[k*OWID +: OWID] = g_st[LV-1].node_q[0][k];
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (en) begin
      out_valid_q <= g_st[LV-1].v_q;
      if (g_st[LV-1].v_q) out_q <= out_d;
    end
  end

  assign out_data_o  = out_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = (|stage_v) || out_valid_q;

endmodule

// File: rtl/synaptic_core.sv
// One synaptic channel: a weight memory written and read through the sparse-spike word,
// producing a single-entry buffered P-lane contribution (weight * count, clamped to MWID).
module synaptic_core
  import synaptic_array_pkg::*;
#(
  parameter int P      = 64,
  parameter int SYNWID = 8,
  parameter int MWID   = 12,
  parameter int DEEPTH = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ipt_valid_i,
  output logic                  ipt_ready_o,
  input  logic [CORE_BUS_W-1:0] sparse_bits_i,
  output logic [P*MWID-1:0]     opt_o,
  output logic                  opt_valid_o,
  input  logic                  opt_ready_i
);

  localparam int AW = $clog2(DEEPTH);

  // word: [31] weight write, [30:24] address, [23:16] reserved, [15:8] spike count, [7:0] weight
  logic signed [SYNWID-1:0] mem_q [DEEPTH];
  logic                     is_wr;
  logic [AW-1:0]            addr;
  logic signed [7:0]        cnt;
  logic signed [SYNWID-1:0] wdata;
  logic signed [SYNWID+7:0] prod;
  logic signed [MWID-1:0]   lane_d;
  logic                     accept;
  logic                     opt_valid_q;
  logic [P*MWID-1:0]        opt_q;
  logic                     unused_rsvd;

  assign is_wr       = sparse_bits_i[31];
  assign addr        = sparse_bits_i[24 +: AW];
  assign cnt         = sparse_bits_i[15:8];
  assign wdata       = sparse_bits_i[SYNWID-1:0];
  assign unused_rsvd = ^sparse_bits_i[23:16];

  assign prod   = mem_q[addr] * cnt;
  assign lane_d = MWID'(sat_clamp(32'(prod), MWID, SYNWID + 8));

  assign ipt_ready_o = !opt_valid_q || opt_ready_i;
  assign accept      = ipt_valid_i && ipt_ready_o;
  assign opt_valid_o = opt_valid_q;
  assign opt_o       = opt_q;

  // weights are configuration and survive reset
  always_ff @(posedge clk_i) begin
    if (accept && is_wr) mem_q[addr] <= wdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      opt_valid_q <= 1'b0;
    end else if (ipt_ready_o) begin
      opt_valid_q <= ipt_valid_i && !is_wr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && !is_wr) opt_q <= {P{lane_d}};
  end

endmodule

// File: rtl/synaptic_array_nway.sv
// N-channel synaptic array: N synaptic_core instances joined under a runtime channel mask
// and summed by reduce_tree. Define SYN_ARRAY_SAT_EN for a saturating output stage.
module synaptic_array_nway
  import synaptic_array_pkg::*;
#(
  parameter int N      = 4,
  parameter int P      = 64,
  parameter int SYNWID = 8,
  parameter int MWID   = 12,
  parameter int DEEPTH = 128
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N-1:0]                ipt_valid_i,
  output logic [N-1:0]                ipt_ready_o,
  input  logic [N*CORE_BUS_W-1:0]     sparse_bits_i,
  input  logic [N-1:0]                chan_en_i,
  output logic [P*sum_w(MWID,N)-1:0]  syn_opt_o,
  output logic                        syn_opt_valid_o,
  input  logic                        syn_opt_ready_i,
  output logic                        busy_o
);

  localparam int CW = P * MWID;

  logic [N-1:0]    core_valid;
  logic [N-1:0]    core_ready;
  logic [N*CW-1:0] core_data;
  logic [N*CW-1:0] tree_data;
  logic            tree_en;
  logic            tree_busy;
  logic            all_joined;
  logic            fire;

  for (genvar c = 0; c < N; c++) begin : g_core
    synaptic_core #(
      .P      (P),
      .SYNWID (SYNWID),
      .MWID   (MWID),
      .DEEPTH (DEEPTH)
    ) u_core (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .ipt_valid_i   (ipt_valid_i[c]),
      .ipt_ready_o   (ipt_ready_o[c]),
      .sparse_bits_i (sparse_bits_i[c*CORE_BUS_W +: CORE_BUS_W]),
      .opt_o         (core_data[c*CW +: CW]),
      .opt_valid_o   (core_valid[c]),
      .opt_ready_i   (core_ready[c])
    );
  end

  always_comb begin
    tree_data = '0;
    for (int c = 0; c < N; c++) begin
      if (chan_en_i[c]) tree_data[c*CW +: CW] = core_data[c*CW +: CW];
    end
  end

  // disabled channels are always drained so a masked core can never stall its producer
  assign all_joined = &(core_valid | ~chan_en_i);
  assign fire       = all_joined && tree_en && (|chan_en_i);
  assign core_ready = fire ? {N{1'b1}} : ~chan_en_i;
  assign busy_o     = tree_busy || (|(core_valid & chan_en_i));

  reduce_tree #(
    .N    (N),
    .P    (P),
    .MWID (MWID)
  ) u_tree (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (fire),
    .in_ready_o  (tree_en),
    .in_data_i   (tree_data),
    .out_data_o  (syn_opt_o),
    .out_valid_o (syn_opt_valid_o),
    .out_ready_i (syn_opt_ready_i),
    .busy_o      (tree_busy)
  );

endmodule

// File: tb/tb_synaptic_array_nway.sv
// Directed bench for synaptic_array_nway: vector table for the sums plus sequences for
// latency, stall, channel masking and mid-flight reset.
module tb_synaptic_array_nway;

  localparam int N      = 4;
  localparam int P      = 64;
  localparam int SYNWID = 8;
  localparam int MWID   = 12;
  localparam int DEEPTH = 128;
  localparam int OWID   = MWID + 2;

  logic              clk;
  logic              rst;
  logic [N-1:0]      ipt_valid;
  logic [N-1:0]      ipt_ready;
  logic [N*32-1:0]   sparse_bits;
  logic [N-1:0]      chan_en;
  logic [P*OWID-1:0] syn_opt;
  logic              syn_opt_valid;
  logic              syn_opt_ready;
  logic              busy;

  synaptic_array_nway #(
    .N(N), .P(P), .SYNWID(SYNWID), .MWID(MWID), .DEEPTH(DEEPTH)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ipt_valid_i     (ipt_valid),
    .ipt_ready_o     (ipt_ready),
    .sparse_bits_i   (sparse_bits),
    .chan_en_i       (chan_en),
    .syn_opt_o       (syn_opt),
    .syn_opt_valid_o (syn_opt_valid),
    .syn_opt_ready_i (syn_opt_ready),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_valid_seen = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int lane(input logic [P*OWID-1:0] d, input int k);
    logic signed [OWID-1:0] t;
    t = d[k*OWID +: OWID];
    return int'(t);
  endfunction

  task automatic check_lanes(input string name, input logic [P*OWID-1:0] d, input int exp);
    int act;
    act = lane(d, 0);
    for (int k = 0; k < P; k++) begin
      if (lane(d, k) != exp) begin
        act = lane(d, k);
        break;
      end
    end
    check(name, act, exp);
  endtask

  function automatic logic [31:0] spk(input int a, input int c);
    logic [6:0] a7;
    logic [7:0] c8;
    a7 = a[6:0];
    c8 = c[7:0];
    return {1'b0, a7, 8'h00, c8, 8'h00};
  endfunction

  function automatic logic [31:0] wrw(input int a, input int w);
    logic [6:0] a7;
    logic [7:0] w8;
    a7 = a[6:0];
    w8 = w[7:0];
    return {1'b1, a7, 8'h00, 8'h00, w8};
  endfunction

  // output monitor: collects handshaked results and checks that a stalled output holds
  logic [P*OWID-1:0] outq[$];
  logic              prev_stall = 1'b0;
  logic [P*OWID-1:0] prev_data;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (syn_opt_valid) n_valid_seen++;
      if (prev_stall) begin
        check("hold_valid", syn_opt_valid, 1);
        check("hold_data_stable", (syn_opt == prev_data), 1);
      end
      if (syn_opt_valid && syn_opt_ready) outq.push_back(syn_opt);
      prev_stall = syn_opt_valid && !syn_opt_ready;
      prev_data  = syn_opt;
    end
  end

  task automatic push(input logic [N-1:0] m, input logic [N*32-1:0] w);
    logic [N-1:0] pend;
    logic [N-1:0] acc;
    int t;
    pend = m;
    t = 0;
    sparse_bits = w;
    ipt_valid = pend;
    while (pend != 0 && t < 100) begin
      @(negedge clk);
      acc = pend & ipt_ready;
      @(posedge clk);
      #1;
      pend = pend & ~acc;
      ipt_valid = pend;
      t++;
    end
    if (pend != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL push_timeout: pending %b, expected 0000", pend);
      ipt_valid = '0;
    end
  endtask

  task automatic push4(input int a, input int c0, input int c1, input int c2, input int c3);
    push(4'hF, {spk(a, c3), spk(a, c2), spk(a, c1), spk(a, c0)});
  endtask

  task automatic wait_out(output logic [P*OWID-1:0] d);
    int t;
    t = 0;
    d = '0;
    while (outq.size() == 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (outq.size() > 0) begin
      d = outq.pop_front();
    end else begin
      n_chk++;
      n_fail++;
      $display("FAIL out_timeout: no result after %0d cycles, expected one", t);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: busy=1, expected 0");
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] en;
    int         addr;
    int         c0, c1, c2, c3;
    int         exp_full;
    int         exp_sat;
  } vec_t;

  localparam int NV = 12;
  vec_t vt[NV];

  initial begin
    logic [P*OWID-1:0] d;
    int n;
    int busy1;
    int seen0;

    // weights: addr0 = 1, addr1 = 127, addr2 = -128 in every core
    vt[0]  = '{4'hF, 0,   1,   2,   3,   4,    10,    10};
    vt[1]  = '{4'h5, 0,   5,   7,   9,  11,    14,    14};
    vt[2]  = '{4'hF, 1, 127, 127, 127, 127,  8188,  2047};
    vt[3]  = '{4'hF, 2, 127, 127, 127, 127, -8192, -2048};
    vt[4]  = '{4'hA, 0,   1,  -6,   3, 100,    94,    94};
    vt[5]  = '{4'h1, 0,   7,  50,  50,  50,     7,     7};
    vt[6]  = '{4'h8, 1,   1,   1,   1,  10,  1270,  1270};
    vt[7]  = '{4'hF, 0,-128,-128, 127,   1,  -128,  -128};
    vt[8]  = '{4'hF, 1,  16,  16,  16,  16,  8128,  2047};
    vt[9]  = '{4'hF, 1,  20, -20,  20, -20,    -2,    -2};
    vt[10] = '{4'h3, 2,   1,   2,   0,   0,  -384,  -384};
    vt[11] = '{4'hF, 2,  -1,  -1,  -1,  -1,   512,   512};

    rst = 1'b1;
    ipt_valid = '0;
    sparse_bits = '0;
    chan_en = 4'hF;
    syn_opt_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", syn_opt_valid, 0);
    check("rst_data", (syn_opt == '0), 1);
    check("rst_busy", busy, 0);
    check("rst_ipt_ready", ipt_ready, 4'hF);
    @(posedge clk);
    #1 rst = 1'b0;

    push(4'hF, {4{wrw(0, 1)}});
    push(4'hF, {4{wrw(1, 127)}});
    push(4'hF, {4{wrw(2, -128)}});
    wait_idle();
    check("wr_no_output", outq.size(), 0);

    // latency: core register, then LV pair-add stages and the output register
    push4(0, 1, 2, 3, 4);
    n = 0;
    busy1 = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) busy1 = busy;
    end while (!syn_opt_valid && n < 20);
    check("busy_inflight", busy1, 1);
    check("fire_latency", n, 4);
    wait_out(d);
    check_lanes("lat_sum", d, 10);

    for (int i = 0; i < NV; i++) begin
      wait_idle();
      chan_en = vt[i].en;
      push4(vt[i].addr, vt[i].c0, vt[i].c1, vt[i].c2, vt[i].c3);
      wait_out(d);
`ifdef SYN_ARRAY_SAT_EN
      check_lanes($sformatf("vec%0d", i), d, vt[i].exp_sat);
`else
      check_lanes($sformatf("vec%0d", i), d, vt[i].exp_full);
`endif
      check($sformatf("vec%0d_drained", i), ipt_ready, 4'hF);
    end

    // backpressure with three results in flight
    wait_idle();
    chan_en = 4'hF;
    syn_opt_ready = 1'b0;
    push4(0, 1, 1, 1, 1);
    push4(0, 2, 2, 2, 2);
    push4(0, 3, 3, 3, 3);
    repeat (10) @(negedge clk);
    check("stall_valid", syn_opt_valid, 1);
    check("stall_no_transfer", outq.size(), 0);
    check_lanes("stall_front", syn_opt, 4);
    @(posedge clk);
    #1 syn_opt_ready = 1'b1;
    wait_out(d);
    check_lanes("order0", d, 4);
    wait_out(d);
    check_lanes("order1", d, 8);
    wait_out(d);
    check_lanes("order2", d, 12);
    repeat (20) @(negedge clk);
    check("no_duplicate", outq.size(), 0);

    // all channels masked: inputs drain, nothing comes out
    wait_idle();
    chan_en = 4'h0;
    seen0 = n_valid_seen;
    for (int r = 0; r < 5; r++) push4(0, r + 1, 1, 1, 1);
    repeat (50) @(negedge clk);
    check("mask0_no_valid", n_valid_seen - seen0, 0);
    check("mask0_busy", busy, 0);
    check("mask0_drained", ipt_ready, 4'hF);
    @(posedge clk);
    #1 chan_en = 4'hF;

    // reset with two results in flight
    push4(0, 1, 1, 1, 1);
    push4(0, 2, 2, 2, 2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_flush_valid", syn_opt_valid, 0);
    check("rst_flush_busy", busy, 0);
    repeat (10) @(negedge clk);
    check("rst_no_residue", outq.size(), 0);
    @(posedge clk);
    #1;
    push4(0, 3, 1, 4, 1);
    wait_out(d);
    check_lanes("post_rst_sum", d, 9);
    wait_idle();
    check("final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
